// File: rtl/m14k_mbist_march.sv
// March C- memory BIST controller: one memory operation per cycle, with
// sticky first-failure capture of address and March element.
module m14k_mbist_march #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              gclk,
    input  logic              greset,
    input  logic              bist_start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [2:0]        elem;
    logic              phase;
    logic [ADDR_W-1:0] addr;

    // Read tracking: the compare happens the cycle after the read is issued
    logic              rd_valid;
    logic [DATA_W-1:0] rd_exp;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_elem;

    logic [2:0]        nxt_elem;
    logic              nxt_phase;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_we;
    logic              last_op;
    logic              miscmp;

    // Background of an operation: writes w1 in M1/M3, reads expect 1 in M2/M4
    function automatic logic bg_of(input logic [2:0] e, input logic w);
        return w ? (e == 3'd1 || e == 3'd3) : (e == 3'd2 || e == 3'd4);
    endfunction

    // Next operation in the March sequence
    always_comb begin
        nxt_elem  = elem;
        nxt_phase = 1'b0;
        nxt_addr  = addr;
        last_op   = 1'b0;
        if (elem != 3'd0 && elem != 3'd5 && !phase) begin
            nxt_phase = 1'b1;
        end else if (addr == ((elem >= 3'd3) ? '0 : ADDR_MAX)) begin
            if (elem == 3'd5) begin
                last_op = 1'b1;
            end else begin
                nxt_elem = elem + 3'd1;
                nxt_addr = (elem >= 3'd2) ? ADDR_MAX : '0;
            end
        end else begin
            nxt_addr = (elem >= 3'd3) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
        nxt_we = (nxt_elem == 3'd0) || nxt_phase;
    end

    assign miscmp = rd_valid && (mem_rdata != rd_exp);

    always_ff @(posedge gclk or posedge greset) begin
        if (greset) begin
            state     <= IDLE;
            elem      <= 3'd0;
            phase     <= 1'b0;
            addr      <= '0;
            rd_valid  <= 1'b0;
            rd_exp    <= '0;
            rd_addr   <= '0;
            rd_elem   <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
        end else begin
            rd_valid <= 1'b0;
            if (miscmp && !bist_fail) begin
                bist_fail <= 1'b1;
                fail_addr <= rd_addr;
                fail_elem <= rd_elem;
            end
            case (state)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state     <= RUN;
                        elem      <= 3'd0;
                        phase     <= 1'b0;
                        addr      <= '0;
                        bist_busy <= 1'b1;
                        bist_done <= 1'b0;
                        bist_fail <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= 3'd0;
                        mem_we    <= 1'b1;
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                RUN: begin
                    rd_valid <= mem_re;
                    rd_exp   <= {DATA_W{bg_of(elem, 1'b0)}};
                    rd_addr  <= addr;
                    rd_elem  <= elem;
                    if (last_op) begin
                        state     <= DRAIN;
                        elem      <= 3'd0;
                        phase     <= 1'b0;
                        addr      <= '0;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        elem      <= nxt_elem;
                        phase     <= nxt_phase;
                        addr      <= nxt_addr;
                        mem_we    <= nxt_we;
                        mem_re    <= !nxt_we;
                        mem_addr  <= nxt_addr;
                        mem_wdata <= nxt_we ? {DATA_W{bg_of(nxt_elem, 1'b1)}} : '0;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    bist_busy <= 1'b0;
                    bist_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m14k_mbist_march.sv
// Bench for m14k_mbist_march: faulty-memory model plus a March C- reference
// that predicts the operation stream and the first failure.
module tb_m14k_mbist_march;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic             we;
        logic             re;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    logic              gclk = 1'b0;
    logic              greset;
    logic              bist_start;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;

    int checks = 0;
    int fails  = 0;

    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] sa0 [N];
    logic [DATA_W-1:0] sa1 [N];

    op_t               q[$];
    logic              exp_fail;
    logic [ADDR_W-1:0] exp_addr;
    logic [2:0]        exp_elem;
    int                ops [6][2];

    m14k_mbist_march #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .gclk(gclk), .greset(greset), .bist_start(bist_start),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .bist_busy(bist_busy),
        .bist_done(bist_done), .bist_fail(bist_fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem)
    );

    always #5 gclk = ~gclk;

    // Synchronous memory; stuck-at faults act on the read path
    always @(posedge gclk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= (mem[mem_addr] & ~sa0[mem_addr]) | sa1[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge gclk) begin
        if (!greset) begin
            chk("we_re_exclusive", 64'(mem_we & mem_re), 64'(0));
            if (!mem_we && !mem_re) chk("idle_bus_zero", 64'({mem_addr, mem_wdata}), 64'(0));
        end
    end

    // Reference: walk the March C- table over a faulty behavioural memory
    task automatic build_model();
        logic [DATA_W-1:0] m [N];
        logic [DATA_W-1:0] v, bgw;
        int a, code;
        q.delete();
        exp_fail = 1'b0;
        exp_addr = '0;
        exp_elem = 3'd0;
        for (int i = 0; i < N; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = (e >= 3) ? N - 1 - k : k;
                for (int p = 0; p < 2; p++) begin
                    code = ops[e][p];
                    if (code < 0) continue;
                    bgw = (code % 2 == 1) ? {DATA_W{1'b1}} : '0;
                    if (code >= 2) begin
                        m[a] = bgw;
                        q.push_back('{1'b1, 1'b0, ADDR_W'(a), bgw});
                    end else begin
                        v = (m[a] & ~sa0[a]) | sa1[a];
                        if (v != bgw && !exp_fail) begin
                            exp_fail = 1'b1;
                            exp_addr = ADDR_W'(a);
                            exp_elem = 3'(e);
                        end
                        q.push_back('{1'b0, 1'b1, ADDR_W'(a), DATA_W'(0)});
                    end
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // One run: pulse_at re-pulses start mid-run, reset_at aborts with greset
    task automatic run_test(input int pulse_at, input int reset_at);
        build_model();
        @(negedge gclk) bist_start = 1'b1;
        @(negedge gclk) bist_start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0)
                chk("start_clears", 64'({bist_done, bist_fail, fail_addr, fail_elem}), 64'(0));
            if (i == reset_at) begin
                greset = 1'b1;
                #1;
                chk("reset_outputs", 64'({mem_addr, mem_wdata, mem_we, mem_re, bist_busy,
                    bist_done, bist_fail, fail_addr, fail_elem}), 64'(0));
                @(negedge gclk) greset = 1'b0;
                repeat (2) @(negedge gclk);
                chk("after_reset_idle", 64'({bist_busy, bist_done, bist_fail, mem_we, mem_re}), 64'(0));
                return;
            end
            chk($sformatf("op%0d", i), 64'({mem_we, mem_re, mem_addr, mem_wdata}), 64'(q[i]));
            chk("busy_run", 64'({bist_busy, bist_done}), 64'(2'b10));
            bist_start = (i == pulse_at);
            @(negedge gclk);
        end
        bist_start = 1'b0;
        chk("drain", 64'({bist_busy, bist_done, mem_we, mem_re}), 64'(4'b1000));
        @(negedge gclk);
        chk("done_result", 64'({bist_busy, bist_done, bist_fail, fail_addr, fail_elem}),
            64'({1'b0, 1'b1, exp_fail, exp_addr, exp_elem}));
        @(negedge gclk);
        chk("done_held", 64'({bist_busy, bist_done, bist_fail}), 64'({1'b0, 1'b1, exp_fail}));
    endtask

    initial begin
        ops[0][0] = 2; ops[0][1] = -1;
        ops[1][0] = 0; ops[1][1] = 3;
        ops[2][0] = 1; ops[2][1] = 2;
        ops[3][0] = 0; ops[3][1] = 3;
        ops[4][0] = 1; ops[4][1] = 2;
        ops[5][0] = 0; ops[5][1] = -1;
        clear_faults();
        greset = 1'b1;
        bist_start = 1'b0;
        repeat (2) @(negedge gclk);
        chk("reset_state", 64'({mem_addr, mem_wdata, mem_we, mem_re, bist_busy,
            bist_done, bist_fail, fail_addr, fail_elem}), 64'(0));
        greset = 1'b0;
        @(negedge gclk);

        // Fault-free run with a start pulse during RUN (must be ignored)
        run_test(7, -1);
        chk("clean_pass", 64'(bist_fail), 64'(0));

        // Bit 0 of address 2 stuck-at-0
        sa0[2] = 8'h01;
        run_test(-1, -1);
        chk("sa0_fail_addr", 64'({bist_fail, fail_addr, fail_elem}), 64'({1'b1, 2'd2, 3'd2}));

        // Addresses 1 and 3 stuck-at-1: first failure kept
        clear_faults();
        sa1[1] = 8'hFF;
        sa1[3] = 8'hFF;
        run_test(-1, -1);
        chk("sa1_first_kept", 64'({bist_fail, fail_addr, fail_elem}), 64'({1'b1, 2'd1, 3'd1}));

        // Restart from DONE after a failing run
        clear_faults();
        sa0[0] = 8'h80;
        run_test(-1, -1);

        // Reset on cycle 15 of a run, then a clean run
        clear_faults();
        run_test(-1, 15);
        run_test(-1, -1);

        // Random fault patterns
        for (int r = 0; r < 6; r++) begin
            clear_faults();
            for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
                if ($urandom_range(0, 1) == 0)
                    sa0[$urandom_range(0, N - 1)] = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
                else
                    sa1[$urandom_range(0, N - 1)] = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
            end
            run_test(int'($urandom_range(0, 45)) - 5, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/m14k_mbist_march.md
M14K_MBIST_MARCH -- requirements
Module: m14k_mbist_march

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 8, giving the memory address width; depth N = 2^ADDR_W.
REQ-002 The block SHALL have a parameter DATA_W, default 32, giving the memory word width.
REQ-003 The block SHALL have port gclk, input, 1 bit: the single clock; all state SHALL be rising-edge triggered.
REQ-004 The block SHALL have port greset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port bist_start, input, 1 bit: a single-cycle pulse that starts a test run.
REQ-006 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid the cycle after mem_re.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-008 The block SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-009 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-010 The block SHALL have port mem_re, output, 1 bit: memory read enable.
REQ-011 The block SHALL have port bist_busy, output, 1 bit: asserted while a run is in progress.
REQ-012 The block SHALL have port bist_done, output, 1 bit: run complete; held high until the next run starts.
REQ-013 The block SHALL have port bist_fail, output, 1 bit: sticky flag set on any read miscompare.
REQ-014 The block SHALL have port fail_addr, output, ADDR_W bits: address of the first miscompare.
REQ-015 The block SHALL have port fail_elem, output, 3 bits: March element index of the first miscompare.

Function
REQ-016 The block SHALL run March C- using backgrounds D0 = all zeros and D1 = all ones, with elements M0 ascending w0; M1 ascending r0,w1; M2 ascending r1,w0; M3 descending r0,w1; M4 descending r1,w0; M5 descending r0.
REQ-017 The block SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE, plus an element counter (0..5), an op-phase bit and an ADDR_W-bit address counter.
REQ-018 The FSM SHALL leave IDLE or DONE for RUN on the cycle after bist_start=1, and on that same edge it SHALL clear bist_done, bist_fail, fail_addr and fail_elem.
REQ-019 bist_start SHALL be ignored while the FSM is in RUN or DRAIN.
REQ-020 The block SHALL issue one memory operation per cycle: an r+w element takes 2 cycles per address (read, then write to the same address); M0 and M5 take 1 cycle per address.
REQ-021 Ascending elements SHALL cover addresses 0..N-1 and descending elements N-1..0; the address counter SHALL wrap without an idle cycle between elements.
REQ-022 mem_we and mem_re SHALL never be high in the same cycle.
REQ-023 When mem_we=0 and mem_re=0, mem_addr and mem_wdata SHALL be 0.
REQ-024 mem_rdata SHALL be compared, one cycle after its mem_re, against the expected background registered with that read.
REQ-025 On the first miscompare the block SHALL set bist_fail and capture fail_addr and fail_elem; later miscompares SHALL NOT overwrite them.
REQ-026 The test SHALL run to completion after a failure (no abort).
REQ-027 After the last M5 read (address 0) the FSM SHALL enter DRAIN for one cycle to compare that read, then enter DONE.
REQ-028 In DONE, bist_done SHALL be 1 and bist_busy 0; in RUN and DRAIN, bist_busy SHALL be 1.
REQ-029 A run SHALL last exactly 10N+1 cycles from the first RUN cycle to the first DONE cycle.
REQ-030 A miscompare detected in DRAIN SHALL be recorded like any other miscompare.

Reset
REQ-031 While greset=1, asynchronously and regardless of state, the FSM SHALL be in IDLE and all outputs, counters and capture registers SHALL be 0.
REQ-032 A greset during RUN SHALL abandon the run with no done or fail indication.
REQ-033 The first bist_start after greset deasserts SHALL begin a fresh run.

Verification
REQ-034 Fault-free run, ADDR_W=2, DATA_W=8: pulse bist_start -> busy for 41 cycles, then bist_done=1, bist_fail=0, and the address sequence matches REQ-016/REQ-021.
REQ-035 Bit 0 of address 2 stuck-at-0: full run -> bist_fail=1, fail_addr=2, fail_elem=2, bist_done=1 after 41 cycles.
REQ-036 Addresses 1 and 3 both stuck-at-1 on all bits: full run -> fail_addr=1, fail_elem=1 (first failure kept).
REQ-037 greset asserted on cycle 15 of a run -> all outputs 0 immediately; a later bist_start gives a clean 41-cycle fault-free run.
REQ-038 bist_start pulsed during RUN -> ignored, with run length unchanged; bist_start pulsed in DONE after a failing run -> bist_done and bist_fail cleared on the next edge and a new run starts.
REQ-039 Every cycle of every run -> assertion checks that mem_we and mem_re are never both 1.
